mac_pe_db: RTL and testbench

- Next-generation systolic-array processing element: a multiply-accumulate cell with a double-buffered weight register.
- Weights for the next tile shift through a dedicated daisy chain into a shadow register while the current tile computes. A swap pulse then promotes the shadow weight to active with zero bubble.
- Adds signed/unsigned operation, optional saturation, a sticky overflow flag and valid propagation on both chains.
- Instantiated N x M inside the systolic array:
  - data flows west->east;
  - partial sums flow north->south;
  - weights and swap flow north->south.

---
 rtl/mac_pe_db.sv | 75 +++++++
 tb/tb_mac_pe_db.sv | 106 ++++++++++
 2 files changed

// File: rtl/mac_pe_db.sv
// mac_pe_db: systolic MAC cell with double-buffered weight, signed/unsigned, saturation and sticky overflow
module mac_pe_db #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter bit SIGNED       = 1,
  parameter bit SATURATE     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid_out,
  input  logic [ACC_WIDTH-1:0]    acc_in,
  output logic [ACC_WIDTH-1:0]    acc_out,
  input  logic [WEIGHT_WIDTH-1:0] weight_in,
  input  logic                    weight_valid_in,
  output logic [WEIGHT_WIDTH-1:0] weight_out,
  output logic                    weight_valid_out,
  input  logic                    swap_in,
  output logic                    swap_out,
  output logic                    ovf
);
  localparam int SW = ACC_WIDTH + 1;
  logic [WEIGHT_WIDTH-1:0] weight_active, weight_shadow;
  logic [SW-1:0] d_x, w_x, a_x, prod, sum;
  logic [ACC_WIDTH-1:0] sat, acc_nxt;
  logic of;
  // The true product fits in ACC_WIDTH bits, so a modulo-2^SW multiply of extended operands is exact
  assign d_x = SIGNED ? {{(SW-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in} : {{(SW-DATA_WIDTH){1'b0}}, data_in};
  assign w_x = SIGNED ? {{(SW-WEIGHT_WIDTH){weight_active[WEIGHT_WIDTH-1]}}, weight_active}
                      : {{(SW-WEIGHT_WIDTH){1'b0}}, weight_active};
  assign a_x = SIGNED ? {acc_in[ACC_WIDTH-1], acc_in} : {1'b0, acc_in};
  assign prod = d_x * w_x;
  assign sum = prod + a_x;
  assign of = SIGNED ? (sum[SW-1] != sum[SW-2]) : sum[SW-1];
  assign sat = !SIGNED ? {ACC_WIDTH{1'b1}} :
               sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign acc_nxt = (of && SATURATE) ? sat : sum[ACC_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_out         <= '0;
      data_valid_out   <= 1'b0;
      acc_out          <= '0;
      weight_out       <= '0;
      weight_valid_out <= 1'b0;
      swap_out         <= 1'b0;
      ovf              <= 1'b0;
      weight_active    <= '0;
      weight_shadow    <= '0;
    end else begin
      swap_out         <= swap_in;
      weight_valid_out <= weight_valid_in;
      if (weight_valid_in) begin
        weight_shadow <= weight_in;
        weight_out    <= weight_in;
      end
      if (swap_in) weight_active <= weight_shadow;
      if (clr) begin
        data_out       <= '0;
        acc_out        <= '0;
        data_valid_out <= 1'b0;
        ovf            <= 1'b0;
      end else begin
        data_valid_out <= data_valid_in;
        if (data_valid_in) begin
          data_out <= data_in;
          acc_out  <= acc_nxt;
          ovf      <= ovf | of;
        end
      end
    end
endmodule

// File: tb/tb_mac_pe_db.sv
// tb_mac_pe_db: directed checks of four mac_pe_db configurations driven by shared stimulus
module tb_mac_pe_db;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [7:0] d = '0, w = '0;
  logic dv = 1'b0, wv = 1'b0, swap = 1'b0;
  logic [31:0] acc = '0;
  logic [7:0] s_do, u_do, s16_do, w16_do, s_wo, u_wo, s16_wo, w16_wo;
  logic s_dvo, u_dvo, s16_dvo, w16_dvo, s_wvo, u_wvo, s16_wvo, w16_wvo;
  logic s_so, u_so, s16_so, w16_so, s_ovf, u_ovf, s16_ovf, w16_ovf;
  logic [31:0] s_acc, u_acc;
  logic [15:0] s16_acc, w16_acc;
  int total = 0, fails = 0;
  always #5 clk = ~clk;
  mac_pe_db u_s (.clk(clk), .rst_n(rst_n), .clr(clr), .data_in(d), .data_valid_in(dv), .data_out(s_do),
    .data_valid_out(s_dvo), .acc_in(acc), .acc_out(s_acc), .weight_in(w), .weight_valid_in(wv), .weight_out(s_wo),
    .weight_valid_out(s_wvo), .swap_in(swap), .swap_out(s_so), .ovf(s_ovf));
  mac_pe_db #(.SIGNED(0)) u_u (.clk(clk), .rst_n(rst_n), .clr(clr), .data_in(d), .data_valid_in(dv), .data_out(u_do),
    .data_valid_out(u_dvo), .acc_in(acc), .acc_out(u_acc), .weight_in(w), .weight_valid_in(wv), .weight_out(u_wo),
    .weight_valid_out(u_wvo), .swap_in(swap), .swap_out(u_so), .ovf(u_ovf));
  mac_pe_db #(.ACC_WIDTH(16)) u_s16 (.clk(clk), .rst_n(rst_n), .clr(clr), .data_in(d), .data_valid_in(dv),
    .data_out(s16_do), .data_valid_out(s16_dvo), .acc_in(acc[15:0]), .acc_out(s16_acc), .weight_in(w),
    .weight_valid_in(wv), .weight_out(s16_wo), .weight_valid_out(s16_wvo), .swap_in(swap), .swap_out(s16_so),
    .ovf(s16_ovf));
  mac_pe_db #(.ACC_WIDTH(16), .SATURATE(0)) u_w16 (.clk(clk), .rst_n(rst_n), .clr(clr), .data_in(d),
    .data_valid_in(dv), .data_out(w16_do), .data_valid_out(w16_dvo), .acc_in(acc[15:0]), .acc_out(w16_acc),
    .weight_in(w), .weight_valid_in(wv), .weight_out(w16_wo), .weight_valid_out(w16_wvo), .swap_in(swap),
    .swap_out(w16_so), .ovf(w16_ovf));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mac(input logic [7:0] dd, input logic [31:0] aa);
    dv = 1'b1; d = dd; acc = aa;
  endtask
  initial begin
    #3;
    chk("rst_acc", s_acc, 0); chk("rst_dvo", {31'b0, s_dvo}, 0); chk("rst_wo", {24'b0, s_wo}, 0);
    chk("rst_so", {31'b0, s_so}, 0); chk("rst_ovf", {31'b0, s_ovf}, 0);
    step(); rst_n = 1'b1;
    // weight 5 -> swap -> 3*5+10
    wv = 1'b1; w = 8'd5; step();
    chk("wload_wo", {24'b0, s_wo}, 5); chk("wload_wvo", {31'b0, s_wvo}, 1);
    wv = 1'b0; swap = 1'b1; step();
    chk("swap_out", {31'b0, s_so}, 1); chk("w_hold", {24'b0, s_wo}, 5); chk("wvo_low", {31'b0, s_wvo}, 0);
    swap = 1'b0; mac(8'd3, 32'd10); step();
    chk("mac_acc", s_acc, 25); chk("mac_do", {24'b0, s_do}, 3); chk("mac_dvo", {31'b0, s_dvo}, 1);
    // active 2, shadow 7 loaded while streaming
    dv = 1'b0; wv = 1'b1; w = 8'd2; step();
    wv = 1'b0; swap = 1'b1; step();
    swap = 1'b0; wv = 1'b1; w = 8'd7; mac(8'd1, 0); step(); chk("db_1", s_acc, 2);
    wv = 1'b0; mac(8'd2, 0); step(); chk("db_2", s_acc, 4);
    mac(8'd3, 0); step(); chk("db_3", s_acc, 6);
    swap = 1'b1; mac(8'd4, 0); step(); chk("db_swap_pre", s_acc, 8);
    swap = 1'b0; mac(8'd4, 0); step(); chk("db_swap_post", s_acc, 28);
    dv = 1'b0; d = 8'd9; acc = 32'd99; step();
    chk("gap_dvo", {31'b0, s_dvo}, 0); chk("gap_acc", s_acc, 28); chk("gap_do", {24'b0, s_do}, 4);
    // weight -3 / 0xFD
    wv = 1'b1; w = 8'hFD; step();
    wv = 1'b0; swap = 1'b1; step();
    swap = 1'b0; mac(8'hFC, 32'hFFFF_FFEC); step();
    chk("sgn_acc", s_acc, 32'hFFFF_FFF8); chk("s16_sgn", {16'b0, s16_acc}, 16'hFFF8);
    chk("uns_sat", u_acc, 32'hFFFF_FFFF); chk("uns_ovf", {31'b0, u_ovf}, 1); chk("sgn_noovf", {31'b0, s_ovf}, 0);
    mac(8'hFC, 32'h100); step();
    chk("uns_acc", u_acc, 32'h0000_FA0C); chk("sgn_acc2", s_acc, 32'd268);
    // weight 127: 16-bit overflow
    dv = 1'b0; wv = 1'b1; w = 8'd127; step();
    wv = 1'b0; swap = 1'b1; step();
    swap = 1'b0; mac(8'd127, 32'd32767); step();
    chk("sat_acc", {16'b0, s16_acc}, 16'h7FFF); chk("sat_ovf", {31'b0, s16_ovf}, 1);
    chk("wrap_acc", {16'b0, w16_acc}, 16'hBF00); chk("wrap_ovf", {31'b0, w16_ovf}, 1);
    chk("s32_acc", s_acc, 32'h0000_BF00); chk("s32_noovf", {31'b0, s_ovf}, 0);
    wv = 1'b1; w = 8'd2; mac(8'd1, 0); step();
    chk("sticky_acc", {16'b0, s16_acc}, 127); chk("sticky_ovf", {31'b0, s16_ovf}, 1);
    wv = 1'b0; clr = 1'b1; swap = 1'b1; mac(8'd5, 32'd1); step();
    chk("clr_acc", {16'b0, s16_acc}, 0); chk("clr_ovf", {31'b0, s16_ovf}, 0); chk("clr_dvo", {31'b0, s16_dvo}, 0);
    chk("clr_do", {24'b0, s16_do}, 0); chk("clr_uovf", {31'b0, u_ovf}, 0); chk("clr_so", {31'b0, s16_so}, 1);
    clr = 1'b0; swap = 1'b0; mac(8'd5, 0); step(); chk("clr_swapped", s_acc, 10);
    // swap coincident with a shadow load
    wv = 1'b1; w = 8'd9; swap = 1'b1; mac(8'd5, 0); step(); chk("swl_0", s_acc, 10);
    wv = 1'b0; mac(8'd1, 0); step(); chk("swl_1", s_acc, 2);
    swap = 1'b0; mac(8'd1, 0); step(); chk("swl_2", s_acc, 9);
    // negative saturation: 127*-128 - 32768
    dv = 1'b0; wv = 1'b1; w = 8'd127; step();
    wv = 1'b0; swap = 1'b1; step();
    swap = 1'b0; mac(8'h80, 32'hFFFF_8000); step();
    chk("neg_sat", {16'b0, s16_acc}, 16'h8000); chk("neg_wrap", {16'b0, w16_acc}, 16'h4080);
    chk("neg_s32", s_acc, 32'hFFFF_4080);
    // asynchronous reset mid-stream
    mac(8'd5, 32'd3); step();
    #2 rst_n = 1'b0; #1;
    chk("arst_acc", s_acc, 0); chk("arst_do", {24'b0, s_do}, 0); chk("arst_dvo", {31'b0, s_dvo}, 0);
    chk("arst_wo", {24'b0, s_wo}, 0); chk("arst_ovf", {31'b0, s16_ovf}, 0);
    step(); rst_n = 1'b1;
    mac(8'd1, 32'd7); step();
    chk("post_rst_acc", s_acc, 7); chk("post_rst_dvo", {31'b0, s_dvo}, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
